// File: rtl/key_filter_multi.sv
// key_filter_multi
// Multi-channel debouncer for active-low mechanical keys. Each channel
// synchronises its raw key, then qualifies level changes with a debounce
// counter, and reports them as a stable level plus one-cycle event pulses.
// Channels share nothing but the clock and reset.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst_n        asynchronous active-low reset
//   key_in       raw asynchronous keys, active-low (0 = pressed)
//   key_out      debounced stable level per channel, active-low
//   key_press    one-cycle pulse per confirmed press
//   key_release  one-cycle pulse per confirmed release
//   key_long     one-cycle pulse once a press has been held LONG_NUM+1
//                cycles after confirmation
module key_filter_multi #(
    parameter int N_KEYS   = 4,
    parameter int CNT_NUM  = 999_999,
    parameter int LONG_NUM = 49_999_999,
    parameter int CNT_W    = 26
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_out,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        HELD       = 2'd2,
        REL_FILT   = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(CNT_NUM);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(LONG_NUM);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        logic             sync1;
        logic             ks;
        state_e           state;
        logic [CNT_W-1:0] deb_cnt;
        logic [CNT_W-1:0] hold_cnt;
        logic             long_done;
        logic             out_r;
        logic             press_r;
        logic             rel_r;
        logic             long_r;

        // Synchroniser resets to the released level so that a key held
        // through reset is seen as a fresh press afterwards.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1 <= 1'b1;
                ks    <= 1'b1;
            end else begin
                // NOTE: non-blocking assignments make both flops sample the
                // pre-edge values, giving a true two-stage pipeline.
                sync1 <= key_in[i];
                ks    <= sync1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= IDLE;
                deb_cnt   <= '0;
                hold_cnt  <= '0;
                long_done <= 1'b0;
                out_r     <= 1'b1;
                press_r   <= 1'b0;
                rel_r     <= 1'b0;
                long_r    <= 1'b0;
            end else begin
                // Event outputs are single-cycle unless re-armed below.
                press_r <= 1'b0;
                rel_r   <= 1'b0;
                long_r  <= 1'b0;

                case (state)
                    IDLE: begin
                        out_r <= 1'b1;
                        if (!ks) begin
                            state   <= PRESS_FILT;
                            deb_cnt <= '0;
                        end
                    end

                    PRESS_FILT: begin
                        if (ks) begin
                            state   <= IDLE;
                            deb_cnt <= '0;
                        end else if (deb_cnt == DEB_MAX) begin
                            state     <= HELD;
                            out_r     <= 1'b0;
                            press_r   <= 1'b1;
                            deb_cnt   <= '0;
                            hold_cnt  <= '0;
                            long_done <= 1'b0;
                        end else begin
                            deb_cnt <= deb_cnt + CNT_ONE;
                        end
                    end

                    HELD: begin
                        out_r <= 1'b0;
                        if (ks) begin
                            state   <= REL_FILT;
                            deb_cnt <= '0;
                        end else if (hold_cnt != HOLD_MAX) begin
                            hold_cnt <= hold_cnt + CNT_ONE;
                        end else if (!long_done) begin
                            // Hold counter is saturated; long_done keeps the
                            // pulse to one per press, surviving release bounces.
                            long_r    <= 1'b1;
                            long_done <= 1'b1;
                        end
                    end

                    REL_FILT: begin
                        if (!ks) begin
                            // Bounce: resume holding without touching hold_cnt.
                            state <= HELD;
                        end else if (deb_cnt == DEB_MAX) begin
                            state    <= IDLE;
                            out_r    <= 1'b1;
                            rel_r    <= 1'b1;
                            deb_cnt  <= '0;
                            hold_cnt <= '0;
                        end else begin
                            deb_cnt <= deb_cnt + CNT_ONE;
                        end
                    end

                    default: begin
                        state    <= IDLE;
                        out_r    <= 1'b1;
                        deb_cnt  <= '0;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end

        assign key_out[i]     = out_r;
        assign key_press[i]   = press_r;
        assign key_release[i] = rel_r;
        assign key_long[i]    = long_r;
    end

endmodule

// File: tb/tb_key_filter_multi.sv
// Testbench for key_filter_multi with CNT_NUM=4, LONG_NUM=10, N_KEYS=4.
// Stimulus pushes expected events (cycle, channel, kind) into a queue; a
// monitor on the falling edge matches every observed pulse against it and
// flags late, early, missing or unexpected events.
module tb_key_filter_multi;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] key_in;
    logic [N-1:0] key_out;
    logic [N-1:0] key_press;
    logic [N-1:0] key_release;
    logic [N-1:0] key_long;

    always #5 clk = ~clk;

    key_filter_multi #(
        .N_KEYS  (N),
        .CNT_NUM (4),
        .LONG_NUM(10),
        .CNT_W   (26)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_out    (key_out),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG} ev_kind_e;

    typedef struct {
        int       cyc;
        int       ch;
        ev_kind_e kind;
    } ev_t;

    ev_t exp_q[$];
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic expect_ev(input int ch, input ev_kind_e kind, input int at);
        ev_t e;
        e.cyc  = at;
        e.ch   = ch;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    // Pair an observed pulse with the oldest pending entry of the same
    // channel and kind, and compare the cycle it was due.
    task automatic match_ev(input int ch, input ev_kind_e kind);
        int idx;
        idx = -1;
        for (int j = 0; j < exp_q.size(); j++) begin
            if (exp_q[j].ch == ch && exp_q[j].kind == kind) begin
                idx = j;
                break;
            end
        end
        if (idx < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_%s ch%0d: got pulse at cycle %0d, expected none",
                     kind.name(), ch, cyc);
        end else begin
            check($sformatf("%s_ch%0d_cycle", kind.name(), ch), cyc, exp_q[idx].cyc);
            exp_q.delete(idx);
        end
    endtask

    logic [N-1:0] prev_out = '1;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_out = key_out;
        end else begin
            for (int ch = 0; ch < N; ch++) begin
                logic [2:0] ev;
                ev = {key_long[ch], key_release[ch], key_press[ch]};
                if ($countones(ev) > 1)
                    check($sformatf("exclusive_ch%0d", ch), {29'd0, ev}, {29'd0, ev & (~ev + 3'd1)});
                if (key_out[ch] != prev_out[ch] && !(key_press[ch] || key_release[ch]))
                    check($sformatf("key_out_change_without_pulse_ch%0d", ch),
                          {31'd0, key_out[ch]}, {31'd0, prev_out[ch]});
                if (ev[0]) begin
                    match_ev(ch, EV_PRESS);
                    check($sformatf("key_out_at_press_ch%0d", ch), {31'd0, key_out[ch]}, 32'd0);
                end
                if (ev[1]) begin
                    match_ev(ch, EV_RELEASE);
                    check($sformatf("key_out_at_release_ch%0d", ch), {31'd0, key_out[ch]}, 32'd1);
                end
                if (ev[2]) match_ev(ch, EV_LONG);
            end
            prev_out = key_out;
            for (int j = exp_q.size() - 1; j >= 0; j--) begin
                if (exp_q[j].cyc <= cyc) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL missing_%s ch%0d: got no pulse, expected at cycle %0d",
                             exp_q[j].kind.name(), exp_q[j].ch, exp_q[j].cyc);
                    exp_q.delete(j);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_key_out"}, {28'd0, key_out}, 32'hF);
        check({tag, "_key_press"}, {28'd0, key_press}, 32'h0);
        check({tag, "_key_release"}, {28'd0, key_release}, 32'h0);
        check({tag, "_key_long"}, {28'd0, key_long}, 32'h0);
    endtask

    // A level driven at falling edge c is first sampled at edge c+1 and
    // reaches key_out seven edges later, at c+8; key_long follows the
    // press by LONG_NUM+1 = 11 cycles.
    initial begin
        rst_n  = 1'b0;
        key_in = '1;
        tick(2);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(3);

        // Channel 0 press, kept held through the next tests.
        key_in[0] = 1'b0;
        expect_ev(0, EV_PRESS, cyc + 8);
        expect_ev(0, EV_LONG, cyc + 19);
        tick(25);

        // Channel 1: 3-cycle glitch, nothing may happen.
        key_in[1] = 1'b0;
        tick(3);
        key_in[1] = 1'b1;
        tick(12);

        // Channel 2: long hold, then release.
        key_in[2] = 1'b0;
        expect_ev(2, EV_PRESS, cyc + 8);
        expect_ev(2, EV_LONG, cyc + 19);
        tick(30);
        key_in[2] = 1'b1;
        expect_ev(2, EV_RELEASE, cyc + 8);
        tick(15);

        // Channel 3: 2-cycle release bounce while held, then real release.
        key_in[3] = 1'b0;
        expect_ev(3, EV_PRESS, cyc + 8);
        expect_ev(3, EV_LONG, cyc + 19);
        tick(25);
        key_in[3] = 1'b1;
        tick(2);
        key_in[3] = 1'b0;
        tick(12);
        key_in[3] = 1'b1;
        expect_ev(3, EV_RELEASE, cyc + 8);
        tick(15);

        // Reset while channel 0 is still held: immediate reset values, then
        // full re-qualification with a fresh press and long press.
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midhold_reset");
        tick(2);
        rst_n = 1'b1;
        expect_ev(0, EV_PRESS, cyc + 8);
        expect_ev(0, EV_LONG, cyc + 19);
        tick(25);
        key_in[0] = 1'b1;
        expect_ev(0, EV_RELEASE, cyc + 8);
        tick(15);

        // All keys on the same edge.
        key_in = '0;
        for (int ch = 0; ch < N; ch++) begin
            expect_ev(ch, EV_PRESS, cyc + 8);
            expect_ev(ch, EV_LONG, cyc + 19);
        end
        tick(20);
        key_in = '1;
        for (int ch = 0; ch < N; ch++) expect_ev(ch, EV_RELEASE, cyc + 8);
        tick(15);

        tick(5);
        check("pending_events", exp_q.size(), 32'd0);
        check("final_key_out", {28'd0, key_out}, 32'hF);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_filter_multi.md
KEY_FILTER_MULTI -- requirements
Module: key_filter_multi

Interface
REQ-001 SHALL have parameter N_KEYS, default 4: number of independent key channels, range 1..16.
REQ-002 SHALL have parameter CNT_NUM, default 999_999: debounce length in clock cycles minus one (20 ms at 50 MHz).
REQ-003 SHALL have parameter LONG_NUM, default 49_999_999: hold time in clock cycles minus one for the long-press event (1 s at 50 MHz).
REQ-004 SHALL have parameter CNT_W, default 26: counter width, with CNT_W >= clog2(max(CNT_NUM, LONG_NUM)+1).
REQ-005 clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 key_in  input  N_KEYS  raw asynchronous keys, active-low (0 = pressed).
REQ-008 key_out  output  N_KEYS  debounced stable level per channel, active-low.
REQ-009 key_press  output  N_KEYS  one-cycle high pulse per confirmed press.
REQ-010 key_release  output  N_KEYS  one-cycle high pulse per confirmed release.
REQ-011 key_long  output  N_KEYS  one-cycle high pulse when a press has been held LONG_NUM+1 cycles after confirmation.

Function
REQ-012 Each channel SHALL be independent: no shared counters, no cross-channel interaction.
REQ-013 Each key_in bit SHALL pass a 2-flop synchroniser; all further logic SHALL use the synchronised bit (ks).
REQ-014 Each channel SHALL run a 4-state FSM: IDLE (key_out=1), PRESS_FILT, HELD (key_out=0), REL_FILT.
REQ-015 IDLE: ks=0 -> PRESS_FILT with debounce counter cleared; otherwise stay.
REQ-016 PRESS_FILT: ks=0 and count<CNT_NUM -> count+1; ks=0 and count==CNT_NUM -> HELD, key_out<=0, key_press pulse, count cleared; ks=1 at any point -> IDLE, count cleared, no pulse.
REQ-017 HELD: ks=1 -> REL_FILT, count cleared; while ks=0, hold counter increments each cycle up to LONG_NUM; on reaching LONG_NUM, key_long SHALL pulse exactly once per press and the counter SHALL saturate.
REQ-018 REL_FILT: ks=1 and count<CNT_NUM -> count+1; ks=1 and count==CNT_NUM -> IDLE, key_out<=1, key_release pulse; ks=0 at any point -> HELD, key_out stays 0, hold counter keeps its value (a bounce does not restart the long-press time and does not re-fire key_long).
REQ-019 Latency: a clean level change on key_in SHALL appear on key_out exactly CNT_NUM+3 rising edges after the first edge that samples the new level (2 synchroniser + CNT_NUM+1 filter).
REQ-020 key_press, key_release and key_long SHALL be registered, high for exactly one cycle, and never asserted in the same cycle on the same channel.
REQ-021 Any glitch shorter than CNT_NUM+1 synchronised cycles SHALL produce no change on any output.
REQ-022 Counters SHALL never wrap; the hold counter saturates at LONG_NUM; the debounce counter never exceeds CNT_NUM.
REQ-023 Undefined FSM encodings SHALL recover to IDLE on the next edge with key_out=1.

Reset
REQ-024 On rst_n=0, asynchronously: all FSMs IDLE, all counters 0, synchroniser flops 1, key_out all 1, key_press/key_release/key_long all 0.
REQ-025 Reset asserted mid-filter or mid-hold SHALL abort with no pulse; after release a held key SHALL be re-qualified from IDLE (full CNT_NUM+3 latency, new key_press pulse).

Verification (CNT_NUM=4, LONG_NUM=10, N_KEYS=4)
REQ-026 key_in[0] 1->0 held -> key_out[0]=0 and key_press[0] one-cycle pulse at edge 7 after first sampled low; other channels unchanged.
REQ-027 key_in[1] low for 3 cycles then high -> no change on key_out[1], no pulses.
REQ-028 key_in[2] held low 30 cycles -> key_press at edge 7, key_long exactly once 11 cycles later, no repeat; then released -> key_release after 7 edges.
REQ-029 key_in[3] held, then 2-cycle high bounce during HELD -> key_out[3] stays 0, no key_release, key_long not re-issued.
REQ-030 All 4 keys pressed on the same edge -> all key_out fall and all key_press pulse on the same cycle.
REQ-031 rst_n pulsed low while key_in[0] held low in HELD -> outputs at reset values immediately; after release key_press[0] re-fires 7 edges later.
